// File: rtl/pkg_parameters.sv
// Shared constants for the integer register file and its scoreboard.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pkg_parameters;

  localparam int XLEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_NUM        = 2 ** REG_ADDR_WIDTH;

  // Index of the hard-wired zero register.
  localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Write-pending scoreboard: one busy bit per register plus RAW/WAW hazard detection.
// Latency: busy bits update on the rising edge; issue_stall is combinational.
// Backpressure: issue_stall holds decode until the producing write-back lands.
//
// Ports:
//   clk, rst              core clock, async active-high reset
//   rs1_addr, rs2_addr    source indices of the presented instruction
//   issue_valid           decode presents an instruction
//   issue_rd_en/issue_rd  destination of the presented instruction
//   wb_en/wb_addr         write-back strobe and index (clears busy)
//   bypass1, bypass2      source N is satisfied by this cycle's write-back
//   issue_stall           hazard: instruction not accepted this cycle
module reg_file_scoreboard
  import pkg_parameters::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic                  issue_valid,
  input  logic                  issue_rd_en,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic                  bypass1,
  input  logic                  bypass2,
  output logic                  issue_stall
);

  localparam int NUM = 2 ** ADDR_WIDTH;

  logic [NUM-1:0] r_busy;
  logic [NUM-1:0] w_busy_nxt;
  logic [NUM-1:0] w_set;
  logic [NUM-1:0] w_clr;
  logic           w_raw1;
  logic           w_raw2;
  logic           w_waw;
  logic           w_accept;
  logic           w_set_en;

  assign w_raw1 = r_busy[rs1_addr] & (rs1_addr != '0) & ~bypass1;
  assign w_raw2 = r_busy[rs2_addr] & (rs2_addr != '0) & ~bypass2;
  // A write-back landing on the same index this cycle retires the old producer,
  // so the new one may claim the register without waiting.
  assign w_waw  = issue_rd_en & r_busy[issue_rd] & ~(wb_en & (wb_addr == issue_rd));

  assign issue_stall = issue_valid & (w_raw1 | w_raw2 | w_waw);
  assign w_accept    = issue_valid & ~issue_stall;
  // x0 never becomes busy.
  assign w_set_en    = w_accept & issue_rd_en & (issue_rd != '0);

  // Per-bit next state: a new producer (set) beats a retiring one (clear).
  for (genvar i = 0; i < NUM; i++) begin : g_busy
    assign w_set[i]      = w_set_en & (issue_rd == ADDR_WIDTH'(i));
    assign w_clr[i]      = wb_en & (wb_addr == ADDR_WIDTH'(i));
    assign w_busy_nxt[i] = w_set[i] | (r_busy[i] & ~w_clr[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_nxt;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// RV32I integer register file (2 read, 1 write) with write-pending scoreboard.
// Latency: reads combinational, writes visible one cycle after wb_en.
// Backpressure: issue_stall on RAW/WAW hazards against outstanding writes.
//
// Build option: define REG_FILE_BYPASS_EN to forward same-cycle write-back
// data to the read ports and suppress the matching RAW stall.
//
// Ports:
//   clk, rst              core clock, async active-high reset
//   rsN_addr / rsN_data   source operand reads (N = 1, 2)
//   issue_valid, issue_rd_en, issue_rd, issue_stall   issue handshake
//   wb_en, wb_addr, wb_data                           write-back port
module reg_file_sb
  import pkg_parameters::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_WIDTH,
  parameter int DATA_WIDTH = XLEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  output logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  output logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  issue_valid,
  input  logic                  issue_rd_en,
  input  logic [ADDR_WIDTH-1:0] issue_rd,
  output logic                  issue_stall,
  input  logic                  wb_en,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [DATA_WIDTH-1:0] wb_data
);

  localparam int NUM = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_regs [NUM];
  logic                  w_bypass1;
  logic                  w_bypass2;

`ifdef REG_FILE_BYPASS_EN
  assign w_bypass1 = wb_en & (wb_addr == rs1_addr) & (wb_addr != '0);
  assign w_bypass2 = wb_en & (wb_addr == rs2_addr) & (wb_addr != '0);
`else
  assign w_bypass1 = 1'b0;
  assign w_bypass2 = 1'b0;
`endif

  // Storage; x0 is never written, so it stays zero from reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_en && (wb_addr != '0)) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  assign rs1_data = w_bypass1 ? wb_data : ((rs1_addr == '0) ? '0 : r_regs[rs1_addr]);
  assign rs2_data = w_bypass2 ? wb_data : ((rs2_addr == '0) ? '0 : r_regs[rs2_addr]);

  reg_file_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .issue_valid (issue_valid),
    .issue_rd_en (issue_rd_en),
    .issue_rd    (issue_rd),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .bypass1     (w_bypass1),
    .bypass2     (w_bypass2),
    .issue_stall (issue_stall)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  import pkg_parameters::*;

  localparam int AW = REG_ADDR_WIDTH;
  localparam int DW = XLEN;
  localparam int N  = REG_NUM;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rs1_addr = '0;
  logic [DW-1:0] rs1_data;
  logic [AW-1:0] rs2_addr = '0;
  logic [DW-1:0] rs2_data;
  logic          issue_valid = 1'b0;
  logic          issue_rd_en = 1'b0;
  logic [AW-1:0] issue_rd = '0;
  logic          issue_stall;
  logic          wb_en = 1'b0;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;

  reg_file_sb dut (
    .clk         (clk),
    .rst         (rst),
    .rs1_addr    (rs1_addr),
    .rs1_data    (rs1_data),
    .rs2_addr    (rs2_addr),
    .rs2_data    (rs2_data),
    .issue_valid (issue_valid),
    .issue_rd_en (issue_rd_en),
    .issue_rd    (issue_rd),
    .issue_stall (issue_stall),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic          rd_en;
    logic [AW-1:0] rd;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
  } stim_t;

  typedef struct {
    int            id;
    logic          stall;
    logic [DW-1:0] d1;
    logic [DW-1:0] d2;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  // Reference model: architectural register values and the set of registers
  // that have an accepted-but-not-yet-written-back producer.
  logic [DW-1:0] m_regs [N];
  bit            m_pend [N];

  int n_checks = 0;
  int n_fail   = 0;
  int n_id     = 0;

  function automatic stim_t mk(input logic v, input logic rd_en, input int rd,
                               input int rs1, input int rs2, input logic we,
                               input int wa, input logic [DW-1:0] wd);
    stim_t s;
    s.v = v; s.rd_en = rd_en; s.rd = AW'(rd); s.rs1 = AW'(rs1); s.rs2 = AW'(rs2);
    s.wb_en = we; s.wb_addr = AW'(wa); s.wb_data = wd;
    return s;
  endfunction

  function automatic bit m_fwd(input logic [AW-1:0] a, input stim_t s);
`ifdef REG_FILE_BYPASS_EN
    return s.wb_en && (s.wb_addr == a) && (a != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [DW-1:0] m_read(input logic [AW-1:0] a, input stim_t s);
    if (a == 0) return '0;
    if (m_fwd(a, s)) return s.wb_data;
    return m_regs[a];
  endfunction

  function automatic bit m_src_waits(input logic [AW-1:0] a, input stim_t s);
    return (a != 0) && m_pend[a] && !m_fwd(a, s);
  endfunction

  function automatic bit m_stall(input stim_t s);
    bit dst_waits;
    dst_waits = s.rd_en && m_pend[s.rd] && !(s.wb_en && s.wb_addr == s.rd);
    return s.v && (m_src_waits(s.rs1, s) || m_src_waits(s.rs2, s) || dst_waits);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  task automatic drive(input stim_t s);
    issue_valid = s.v;  issue_rd_en = s.rd_en; issue_rd = s.rd;
    rs1_addr = s.rs1;   rs2_addr = s.rs2;
    wb_en = s.wb_en;    wb_addr = s.wb_addr;   wb_data = s.wb_data;
  endtask

  // One clock cycle: drive, predict, queue the prediction, then advance the model.
  // Called just after a rising edge.
  task automatic cycle(input stim_t s);
    exp_t e;
    bit   st;
    drive(s);
    st      = m_stall(s);
    e.id    = n_id;
    e.stall = st;
    e.d1    = m_read(s.rs1, s);
    e.d2    = m_read(s.rs2, s);
    n_id++;
    q.push_back(e);
    @(posedge clk);
    if (s.wb_en) begin
      if (s.wb_addr != 0) m_regs[s.wb_addr] = s.wb_data;
      m_pend[s.wb_addr] = 1'b0;
    end
    if (s.v && !st && s.rd_en && s.rd != 0) m_pend[s.rd] = 1'b1;
    #1;
  endtask

  // Reset pulse with a write-back presented during it; that write must be lost.
  task automatic pulse_reset(input int wa, input logic [DW-1:0] wd);
    drive(mk(0, 0, 0, 0, 0, 1, wa, wd));
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, '0));
    model_clear();
  endtask

  // Monitor: the outputs are combinational and present every cycle, so one
  // queued prediction is consumed per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && q.size() > 0) begin
      mon_e = q.pop_front();
      n_checks++;
      if (issue_stall !== mon_e.stall) begin
        n_fail++;
        $display("FAIL stall id=%0d got %0b exp %0b", mon_e.id, issue_stall, mon_e.stall);
      end
      n_checks++;
      if (rs1_data !== mon_e.d1) begin
        n_fail++;
        $display("FAIL rs1_data id=%0d got %h exp %h", mon_e.id, rs1_data, mon_e.d1);
      end
      n_checks++;
      if (rs2_data !== mon_e.d2) begin
        n_fail++;
        $display("FAIL rs2_data id=%0d got %h exp %h", mon_e.id, rs2_data, mon_e.d2);
      end
    end
  end

  function automatic int rnd_idx();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(0, N - 1));
    return int'($urandom_range(0, 7));
  endfunction

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state: reads of x5/x0 are zero, no stall.
    cycle(mk(0, 0, 0, 5, 0, 0, 0, '0));
    cycle(mk(1, 0, 0, 5, 0, 0, 0, '0));

    // x0: write dropped, busy[0] never sets.
    cycle(mk(0, 0, 0, 0, 0, 1, 0, 32'hDEADBEEF));
    cycle(mk(1, 1, 0, 0, 0, 0, 0, '0));
    cycle(mk(1, 1, 0, 0, 0, 0, 0, '0));

    // RAW on x3, released by write-back (bypass-dependent timing).
    cycle(mk(1, 1, 3, 0, 0, 0, 0, '0));
    cycle(mk(1, 0, 0, 3, 0, 0, 0, '0));
    cycle(mk(1, 0, 0, 3, 0, 1, 3, 32'h0000_1234));
    cycle(mk(1, 0, 0, 3, 0, 0, 0, '0));

    // WAW on x4; accepted alongside its retiring write-back, set wins.
    cycle(mk(1, 1, 4, 0, 0, 0, 0, '0));
    cycle(mk(1, 1, 4, 0, 0, 0, 0, '0));
    cycle(mk(1, 1, 4, 0, 0, 1, 4, 32'h4444_0000));
    cycle(mk(1, 0, 0, 4, 4, 0, 0, '0));
    cycle(mk(1, 1, 4, 0, 0, 0, 0, '0));
    cycle(mk(0, 0, 0, 0, 0, 1, 4, 32'h4444_0001));
    cycle(mk(1, 0, 0, 4, 0, 0, 0, '0));

    // Write to a register with no pending producer.
    cycle(mk(0, 0, 0, 0, 0, 1, 31, 32'hA5A5_A5A5));
    cycle(mk(1, 0, 0, 0, 31, 0, 0, '0));

    // Back-to-back producers, write-backs in reverse order.
    cycle(mk(1, 1, 1, 0, 0, 0, 0, '0));
    cycle(mk(1, 1, 2, 0, 0, 0, 0, '0));
    cycle(mk(1, 0, 0, 1, 2, 0, 0, '0));
    cycle(mk(1, 0, 0, 2, 0, 1, 2, 32'h0000_2222));
    cycle(mk(1, 0, 0, 2, 0, 0, 0, '0));
    cycle(mk(1, 0, 0, 1, 0, 0, 0, '0));
    cycle(mk(1, 0, 0, 1, 2, 1, 1, 32'h0000_1111));
    cycle(mk(1, 0, 0, 1, 2, 0, 0, '0));

    // Mid-operation reset with x7 written and pending.
    cycle(mk(0, 0, 0, 0, 0, 1, 7, 32'h7777_7777));
    cycle(mk(1, 1, 7, 0, 0, 0, 0, '0));
    cycle(mk(1, 0, 0, 7, 0, 0, 0, '0));
    pulse_reset(9, 32'h9999_9999);
    cycle(mk(1, 1, 7, 7, 9, 0, 0, '0));
    cycle(mk(0, 0, 0, 0, 0, 1, 7, 32'h0000_0007));

    // Randomized traffic concentrated on a few registers to provoke hazards.
    for (int k = 0; k < 1500; k++) begin
      cycle(mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_idx(),
               rnd_idx(), rnd_idx(), 1'($urandom_range(0, 1)), rnd_idx(), $urandom()));
    end

    cycle(mk(0, 0, 0, 0, 0, 0, 0, '0));
    for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
